alu_op_arbiter: RTL and testbench

Parametrised multi-channel operand buffer and arbiter feeding the single ALU request port. Each of `CHANNELS` producers (DPI/SystemC transactors or RTL masters) pushes `{a, b, op}` transactions into a private FIFO. A round-robin arbiter drains the FIFOs into one registered, channel-tagged output stage with valid/ready flow control. It is the generalised successor of the single-channel scalar bridge between the co-simulation type layer and the ALU core, and sits directly in front of the ALU input.

---
 rtl/alu_op_arbiter.sv | 163 ++++++++++++++++
 tb/tb_alu_op_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_arbiter.sv
// alu_op_arbiter: per-channel operand FIFOs drained round-robin into one
// registered, channel-tagged valid/ready output stage in front of the ALU.
module alu_op_arbiter #(
    parameter int DATA_W   = 8,
    parameter int OP_W     = 4,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4,
    parameter int TAG_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int LVL_W    = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS-1:0]        req_valid,
    output logic [CHANNELS-1:0]        req_ready,
    input  logic [CHANNELS*DATA_W-1:0] req_a,
    input  logic [CHANNELS*DATA_W-1:0] req_b,
    input  logic [CHANNELS*OP_W-1:0]   req_op,
    output logic                       alu_valid,
    input  logic                       alu_ready,
    output logic [DATA_W-1:0]          alu_a,
    output logic [DATA_W-1:0]          alu_b,
    output logic [OP_W-1:0]            alu_op,
    output logic [TAG_W-1:0]           alu_tag,
    output logic [CHANNELS*LVL_W-1:0]  level,
    output logic [CHANNELS-1:0]        overflow
);

    // DEPTH is a power of two, so the pointer is index bits plus one wrap bit.
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [TAG_W-1:0] LAST_CH = TAG_W'(CHANNELS - 1);

    logic [CHANNELS-1:0] nonempty;
    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;

    logic [DATA_W-1:0] head_a  [CHANNELS];
    logic [DATA_W-1:0] head_b  [CHANNELS];
    logic [OP_W-1:0]   head_op [CHANNELS];

    logic [TAG_W-1:0]  rr_reg;
    logic [TAG_W-1:0]  rr_next;
    logic [TAG_W-1:0]  grant;
    logic              load;

    logic              alu_valid_reg;
    logic [DATA_W-1:0] alu_a_reg;
    logic [DATA_W-1:0] alu_b_reg;
    logic [OP_W-1:0]   alu_op_reg;
    logic [TAG_W-1:0]  alu_tag_reg;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [DATA_W-1:0] mem_a  [DEPTH];
        logic [DATA_W-1:0] mem_b  [DEPTH];
        logic [OP_W-1:0]   mem_op [DEPTH];
        logic [LVL_W-1:0]  wr_ptr_reg;
        logic [LVL_W-1:0]  rd_ptr_reg;
        logic              ovf_reg;
        logic [IDX_W-1:0]  wr_idx;
        logic [IDX_W-1:0]  rd_idx;

        assign wr_idx = wr_ptr_reg[IDX_W-1:0];
        assign rd_idx = rd_ptr_reg[IDX_W-1:0];

        // Readiness depends only on registered pointers: a full FIFO refuses
        // a push even when it is being popped on the same edge.
        assign full[gi]     = (wr_idx == rd_idx) &&
                              (wr_ptr_reg[LVL_W-1] != rd_ptr_reg[LVL_W-1]);
        assign nonempty[gi] = (wr_ptr_reg != rd_ptr_reg);
        assign push[gi]     = req_valid[gi] & ~full[gi];

        assign req_ready[gi]                 = ~full[gi];
        assign level[gi*LVL_W +: LVL_W]      = wr_ptr_reg - rd_ptr_reg;
        assign overflow[gi]                  = ovf_reg;

        // Head entry is read combinationally; the output register captures it.
        assign head_a[gi]  = mem_a[rd_idx];
        assign head_b[gi]  = mem_b[rd_idx];
        assign head_op[gi] = mem_op[rd_idx];

        // Pointer advance and sticky overflow flag for this channel.
        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                ovf_reg    <= 1'b0;
            end else begin
                if (push[gi]) begin
                    wr_ptr_reg <= wr_ptr_reg + LVL_W'(1);
                end
                if (pop[gi]) begin
                    rd_ptr_reg <= rd_ptr_reg + LVL_W'(1);
                end
                if (req_valid[gi] && full[gi]) begin
                    ovf_reg <= 1'b1;
                end
            end
        end

        // Storage write; contents need no reset since pointers gate visibility.
        always_ff @(posedge clk) begin
            if (push[gi]) begin
                mem_a[wr_idx]  <= req_a[gi*DATA_W +: DATA_W];
                mem_b[wr_idx]  <= req_b[gi*DATA_W +: DATA_W];
                mem_op[wr_idx] <= req_op[gi*OP_W +: OP_W];
            end
        end
    end

    // Round-robin grant: lowest non-empty channel at or after rr, else the
    // lowest non-empty channel overall (wrap-around).
    always_comb begin
        grant = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (nonempty[c]) begin
                grant = TAG_W'(c);
            end
        end
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (nonempty[c] && (c >= int'(rr_reg))) begin
                grant = TAG_W'(c);
            end
        end
    end

    // Load when the output slot is free or being consumed, and pop the winner.
    always_comb begin
        load    = (~alu_valid_reg | alu_ready) & (|nonempty);
        rr_next = (grant == LAST_CH) ? '0 : grant + TAG_W'(1);
        pop     = '0;
        if (load) begin
            pop[grant] = 1'b1;
        end
    end

    // Output stage and round-robin pointer; held stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_valid_reg <= 1'b0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_op_reg    <= '0;
            alu_tag_reg   <= '0;
            rr_reg        <= '0;
        end else if (load) begin
            alu_valid_reg <= 1'b1;
            alu_a_reg     <= head_a[grant];
            alu_b_reg     <= head_b[grant];
            alu_op_reg    <= head_op[grant];
            alu_tag_reg   <= grant;
            rr_reg        <= rr_next;
        end else if (alu_ready) begin
            alu_valid_reg <= 1'b0;
        end
    end

    assign alu_valid = alu_valid_reg;
    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_op    = alu_op_reg;
    assign alu_tag   = alu_tag_reg;

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Testbench for alu_op_arbiter: queue-based reference model, checked every cycle.
module tb_alu_op_arbiter;

    localparam int C  = 4;
    localparam int DW = 8;
    localparam int OW = 4;
    localparam int D  = 4;
    localparam int TW = 2;
    localparam int LW = 3;

    logic            clk;
    logic            rst;
    logic [C-1:0]    req_valid;
    logic [C-1:0]    req_ready;
    logic [C*DW-1:0] req_a;
    logic [C*DW-1:0] req_b;
    logic [C*OW-1:0] req_op;
    logic            alu_valid;
    logic            alu_ready;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [OW-1:0]   alu_op;
    logic [TW-1:0]   alu_tag;
    logic [C*LW-1:0] level;
    logic [C-1:0]    overflow;

    alu_op_arbiter #(
        .DATA_W  (DW),
        .OP_W    (OW),
        .CHANNELS(C),
        .DEPTH   (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_op   (req_op),
        .alu_valid(alu_valid),
        .alu_ready(alu_ready),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_tag  (alu_tag),
        .level    (level),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: one queue of {a,b,op} per channel plus output slot.
    logic [DW+DW+OW-1:0] mq [C][$];
    logic          mv;
    logic [DW-1:0] ma;
    logic [DW-1:0] mb;
    logic [OW-1:0] mop;
    logic [TW-1:0] mtag;
    int            mrr;
    logic [C-1:0]  movf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge to the model using the inputs present at that edge.
    task automatic model_edge();
        int pre [C];
        bit any;
        int g;
        logic [DW+DW+OW-1:0] item;
        if (rst) begin
            for (int i = 0; i < C; i++) mq[i].delete();
            mv = 0; ma = 0; mb = 0; mop = 0; mtag = 0; mrr = 0; movf = 0;
            return;
        end
        any = 0;
        for (int i = 0; i < C; i++) begin
            pre[i] = mq[i].size();
            if (pre[i] > 0) any = 1;
        end
        if ((!mv || alu_ready) && any) begin
            g = -1;
            for (int k = 0; k < C; k++) begin
                int idx;
                idx = (mrr + k) % C;
                if (g < 0 && pre[idx] > 0) g = idx;
            end
            item = mq[g].pop_front();
            mv = 1;
            {ma, mb, mop} = item;
            mtag = TW'(g);
            mrr = (g + 1) % C;
        end else if (alu_ready) begin
            mv = 0;
        end
        for (int i = 0; i < C; i++) begin
            if (req_valid[i]) begin
                if (pre[i] < D)
                    mq[i].push_back({req_a[i*DW +: DW], req_b[i*DW +: DW], req_op[i*OW +: OW]});
                else
                    movf[i] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [C*LW-1:0] lvl_exp;
        logic [C-1:0]    rdy_exp;
        for (int i = 0; i < C; i++) begin
            lvl_exp[i*LW +: LW] = LW'(mq[i].size());
            rdy_exp[i]          = (mq[i].size() < D);
        end
        chk("alu_valid", alu_valid, mv);
        chk("alu_a", alu_a, ma);
        chk("alu_b", alu_b, mb);
        chk("alu_op", alu_op, mop);
        chk("alu_tag", alu_tag, mtag);
        chk("level", level, lvl_exp);
        chk("req_ready", req_ready, rdy_exp);
        chk("overflow", overflow, movf);
    endtask

    // One clock: model follows the edge, DUT is sampled on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_ch(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [OW-1:0] op);
        req_a[i*DW +: DW]  = a;
        req_b[i*DW +: DW]  = b;
        req_op[i*OW +: OW] = op;
    endtask

    task automatic rand_data();
        req_a  = 32'($urandom);
        req_b  = 32'($urandom);
        req_op = 16'($urandom);
    endtask

    initial begin
        // Reset held two cycles with random inputs.
        rst = 1'b1;
        req_valid = 4'($urandom);
        alu_ready = 1'($urandom);
        rand_data();
        cycle();
        req_valid = 4'($urandom);
        rand_data();
        cycle();
        chk("rst_ready", req_ready, 4'hf);
        chk("rst_level", level, 12'h0);
        rst = 1'b0;
        req_valid = '0;
        cycle();

        // Single transaction on ch0 with a ready ALU.
        alu_ready = 1'b1;
        set_ch(0, 8'h12, 8'h34, 4'h3);
        req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        cycle();
        chk("single_valid", alu_valid, 1'b1);
        chk("single_a", alu_a, 8'h12);
        chk("single_b", alu_b, 8'h34);
        chk("single_op", alu_op, 4'h3);
        chk("single_tag", alu_tag, 2'd0);
        cycle();
        chk("single_drop", alu_valid, 1'b0);

        // Fill ch1 while the output slot is occupied and stalled.
        alu_ready = 1'b0;
        set_ch(0, 8'($urandom), 8'($urandom), 4'($urandom));
        req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        cycle();
        for (int w = 0; w < 5; w++) begin
            set_ch(1, 8'($urandom), 8'($urandom), 4'($urandom));
            req_valid = 4'b0010;
            cycle();
            if (w == 3) begin
                chk("fill_ready1", req_ready[1], 1'b0);
                chk("fill_level1", level[1*LW +: LW], 3'd4);
            end
        end
        chk("fill_ovf1", overflow[1], 1'b1);
        req_valid = '0;
        alu_ready = 1'b1;
        repeat (8) cycle();
        chk("fill_drained", level[1*LW +: LW], 3'd0);

        // Fairness: three words on every channel, then a round without ch2.
        alu_ready = 1'b0;
        for (int w = 0; w < 3; w++) begin
            rand_data();
            req_valid = 4'hf;
            cycle();
        end
        req_valid = '0;
        alu_ready = 1'b1;
        repeat (6) cycle();
        rand_data();
        req_valid = 4'b1011;
        cycle();
        req_valid = '0;
        repeat (10) cycle();

        // Stall/wrap: ten words through ch0 with alu_ready toggling.
        begin
            int pushed;
            int n;
            pushed = 0;
            n = 0;
            while (pushed < 10 && n < 200) begin
                req_valid = '0;
                if (mq[0].size() < D) begin
                    set_ch(0, 8'($urandom), 8'($urandom), 4'($urandom));
                    req_valid = 4'b0001;
                    pushed++;
                end
                alu_ready = (n % 2) == 0;
                cycle();
                n++;
            end
            chk("wrap_pushed", pushed, 10);
            req_valid = '0;
            for (int k = 0; k < 24; k++) begin
                alu_ready = (k % 2) == 0;
                cycle();
            end
        end

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            rand_data();
            req_valid = 4'($urandom);
            alu_ready = ($urandom % 4) != 0;
            cycle();
        end

        // Mid-stream reset with partially full FIFOs and a held output.
        alu_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            rand_data();
            req_valid = 4'($urandom) | 4'b0001;
            cycle();
        end
        chk("pre_rst_valid", alu_valid, 1'b1);
        rst = 1'b1;
        req_valid = 4'($urandom);
        cycle();
        rst = 1'b0;
        req_valid = '0;
        chk("mid_rst_valid", alu_valid, 1'b0);
        chk("mid_rst_level", level, 12'h0);
        chk("mid_rst_ovf", overflow, 4'h0);
        alu_ready = 1'b1;
        repeat (2) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
